// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start, LSB-first data, optional parity, stop.
module uart_tx #(
  parameter int DATA_WIDTH     = 8,
  parameter int Prescale_width = 6
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [Prescale_width-1:0] Prescale,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      Data_Valid,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  output logic                      TX_OUT,
  output logic                      Busy
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                    state_q, state_d;
  logic [DATA_WIDTH-1:0]     shift_q, shift_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic                      par_en_q, par_en_d;
  logic                      par_typ_q, par_typ_d;
  logic [Prescale_width-1:0] presc_q, presc_d;
  logic [Prescale_width-1:0] cnt_q, cnt_d;
  logic [BW-1:0]             bit_q, bit_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;

  logic [Prescale_width-1:0] presc_eff;
  logic                      bit_end;

  assign presc_eff = (Prescale == '0) ? Prescale_width'(1) : Prescale;
  assign bit_end   = (cnt_q == presc_q - Prescale_width'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      presc_q   <= '0;
      cnt_q     <= '0;
      bit_q     <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    presc_d   = presc_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    busy_d    = busy_q;

    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + Prescale_width'(1);
    end

    // Acceptance is shared by IDLE and the last stop edge so back-to-back
    // frames start without an idle gap.
    if ((state_q == IDLE || (state_q == STOP && bit_end)) && Data_Valid) begin
      state_d   = START;
      tx_d      = 1'b0;
      busy_d    = 1'b1;
      shift_d   = P_DATA;
      data_d    = P_DATA;
      par_en_d  = PAR_EN;
      par_typ_d = PAR_TYP;
      presc_d   = presc_eff;
      cnt_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_d   = 1'b1;
          busy_d = 1'b0;
        end
        START: begin
          if (bit_end) begin
            state_d = DATA;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            bit_d   = '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_q == BW'(DATA_WIDTH - 1)) begin
              if (par_en_q) begin
                state_d = PARITY;
                tx_d    = ^data_q ^ par_typ_q;
              end else begin
                state_d = STOP;
                tx_d    = 1'b1;
              end
            end else begin
              bit_d   = bit_q + BW'(1);
              tx_d    = shift_q[0];
              shift_d = shift_q >> 1;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - Scoreboard bench for uart_tx: queued expected frames, line monitor.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] Prescale;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       TX_OUT;
  logic       Busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [0:10] bits;
    int          nbits;
    int          presc;
    bit          abort;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  uart_tx #(.DATA_WIDTH(8), .Prescale_width(6)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .Prescale   (Prescale),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [0:10] bits, input int nbits, input int presc,
                      input bit abort, input string name);
    exp_t e;
    e.bits  = bits;
    e.nbits = nbits;
    e.presc = presc;
    e.abort = abort;
    e.name  = name;
    exp_q.push_back(e);
  endtask

  task automatic count_busy(input int req, input string name);
    int cnt = 0;
    for (int k = 0; k < 5000; k++) begin
      if (Busy === 1'b1) cnt++;
      else break;
      @(negedge clk);
    end
    check(name, cnt, req);
  endtask

  task automatic frame(input logic [7:0] w, input logic [5:0] p, input bit pen, input bit ptyp,
                       input logic [0:10] bits, input int peff, input int busy_req,
                       input string name);
    push(bits, pen ? 11 : 10, peff, 1'b0, name);
    @(negedge clk);
    P_DATA = w; Prescale = p; PAR_EN = pen; PAR_TYP = ptyp; Data_Valid = 1'b1;
    @(negedge clk);
    Data_Valid = 1'b0;
    count_busy(busy_req, {name, "_busy"});
  endtask

  // Monitor: a low line sampled while out of reset marks a start bit.
  initial begin : monitor
    exp_t        e;
    logic [0:10] act;
    bit          glitch, busy_bad, aborted;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && TX_OUT === 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: start bit seen with empty scoreboard");
          for (int k = 0; k < 2000 && Busy !== 1'b0; k++) @(negedge clk);
        end else begin
          e = exp_q.pop_front();
          act = '0; glitch = 0; busy_bad = 0; aborted = 0;
          for (int b = 0; b < e.nbits && !aborted; b++) begin
            for (int c = 0; c < e.presc && !aborted; c++) begin
              if (!(b == 0 && c == 0)) @(negedge clk);
              if (reset_n !== 1'b1) aborted = 1;
              else begin
                if (c == 0) act[b] = TX_OUT;
                else if (TX_OUT !== act[b]) glitch = 1;
                if (Busy !== 1'b1) busy_bad = 1;
              end
            end
          end
          checks++;
          if (aborted != e.abort ||
              (!aborted && (act !== e.bits || glitch || busy_bad))) begin
            errors++;
            $display("FAIL frame_%s: got bits=%b glitch=%0d busy_bad=%0d aborted=%0d expected bits=%b aborted=%0d",
                     e.name, act, glitch, busy_bad, aborted, e.bits, e.abort);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    bit idle_ok;
    reset_n = 1'b0; Prescale = 6'd8; P_DATA = 8'h00; Data_Valid = 1'b0;
    PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx", TX_OUT, 1);
    check("reset_busy", Busy, 0);
    reset_n = 1'b1;

    idle_ok = 1;
    repeat (100) begin
      @(negedge clk);
      if (TX_OUT !== 1'b1 || Busy !== 1'b0) idle_ok = 0;
    end
    check("idle_100", idle_ok, 1);

    frame(8'hA5, 6'd8, 1'b0, 1'b0, 11'b0_10100101_1_0, 8, 80, "a5_p8");
    frame(8'h07, 6'd4, 1'b1, 1'b0, 11'b0_11100000_1_1, 4, 44, "07_even");
    frame(8'h07, 6'd4, 1'b1, 1'b1, 11'b0_11100000_0_1, 4, 44, "07_odd");

    push(11'b0_10101010_1_0, 10, 4, 1'b0, "b2b_55");
    push(11'b0_11111111_1_0, 10, 4, 1'b0, "b2b_ff");
    @(negedge clk);
    P_DATA = 8'h55; Prescale = 6'd4; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    @(negedge clk);
    P_DATA = 8'hFF;
    begin
      int cnt = 0;
      for (int k = 0; k < 5000; k++) begin
        if (Busy === 1'b1) cnt++;
        else break;
        if (cnt == 41) Data_Valid = 1'b0;
        @(negedge clk);
      end
      Data_Valid = 1'b0;
      check("b2b_busy", cnt, 80);
    end

    fork
      frame(8'h3C, 6'd4, 1'b0, 1'b0, 11'b0_00111100_1_0, 4, 40, "ignored");
      begin
        repeat (12) @(negedge clk);
        P_DATA = 8'h00; Prescale = 6'd2; PAR_EN = 1'b1; Data_Valid = 1'b1;
        @(negedge clk);
        Data_Valid = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    check("no_extra_frame", Busy, 0);

    frame(8'h81, 6'd0, 1'b0, 1'b0, 11'b0_10000001_1_0, 1, 10, "presc0");

    push(11'b0_01010101_1_0, 10, 8, 1'b1, "abort");
    @(negedge clk);
    P_DATA = 8'hAA; Prescale = 6'd8; PAR_EN = 1'b0; Data_Valid = 1'b1;
    @(negedge clk);
    Data_Valid = 1'b0;
    repeat (30) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_tx", TX_OUT, 1);
    check("abort_busy", Busy, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_abort_idle", {Busy, TX_OUT}, 2'b01);

    frame(8'h07, 6'd2, 1'b1, 1'b1, 11'b0_11100000_0_1, 2, 22, "post_reset");

    repeat (10) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
